// File: rtl/udma_hyper_evt_router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : udma_hyper_evt_router_pkg
// Description : Shared types and constants for the HyperBus EOT event router.
// Revision    : 1.0 - initial release
// ============================================================================
package udma_hyper_evt_router_pkg;

    // Transfer direction of one HyperBus channel. 2'b11 is illegal.
    typedef enum logic [1:0] {
        DIR_NONE  = 2'b00,
        DIR_READ  = 2'b01,
        DIR_WRITE = 2'b10
    } hyper_dir_e;

    // Default width of the per-channel done counters.
    localparam int HYPER_EVT_CNT_W = 8;

    // Map any raw 2-bit direction onto a legal one; the illegal code recovers to DIR_NONE.
    function automatic hyper_dir_e hyper_dir_sanitize(input logic [1:0] raw);
        hyper_dir_e dir;
        case (raw)
            2'b01:   dir = DIR_READ;
            2'b10:   dir = DIR_WRITE;
            default: dir = DIR_NONE;
        endcase
        return dir;
    endfunction

endpackage
`default_nettype wire

// File: rtl/udma_hyper_evt_ch.sv
`default_nettype none
// ============================================================================
// Module      : udma_hyper_evt_ch
// Description : One HyperBus channel: direction tracking, EOT classification,
//               registered done pulses, saturating counters, sticky flags.
// Revision    : 1.0 - initial release
// ============================================================================
module udma_hyper_evt_ch
    import udma_hyper_evt_router_pkg::*;
#(
    parameter int CNT_WIDTH = HYPER_EVT_CNT_W
) (
    input  logic                 sys_clk_i,
    input  logic                 rstn_i,
    input  logic                 rx_evt_i,
    input  logic                 tx_evt_i,
    input  logic                 eot_i,
    input  logic                 rd_mask_i,
    input  logic                 wr_mask_i,
    input  logic                 cnt_clr_i,
    output logic                 rd_done_o,
    output logic                 wr_done_o,
    output hyper_dir_e           dir_o,
    output logic [CNT_WIDTH-1:0] rd_cnt_o,
    output logic [CNT_WIDTH-1:0] wr_cnt_o,
    output logic                 orphan_o,
    output logic                 conflict_o
);

    localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;

    hyper_dir_e           r_dir;
    logic                 r_rd_done;
    logic                 r_wr_done;
    logic [CNT_WIDTH-1:0] r_rd_cnt;
    logic [CNT_WIDTH-1:0] r_wr_cnt;
    logic                 r_orphan;
    logic                 r_conflict;

    hyper_dir_e           w_dir_next;
    logic                 w_conflict_evt;
    logic                 w_rd_evt;
    logic                 w_wr_evt;
    logic                 w_orphan_evt;

    // Next direction; EOT is classified against it so a same-cycle RX/TX event wins.
    always_comb begin
        w_dir_next = hyper_dir_sanitize(r_dir);
        if (rx_evt_i && !tx_evt_i) begin
            w_dir_next = DIR_READ;
        end else if (tx_evt_i && !rx_evt_i) begin
            w_dir_next = DIR_WRITE;
        end
        w_conflict_evt = rx_evt_i && tx_evt_i;
        w_rd_evt       = eot_i && (w_dir_next == DIR_READ);
        w_wr_evt       = eot_i && (w_dir_next == DIR_WRITE);
        w_orphan_evt   = eot_i && (w_dir_next == DIR_NONE);
    end

    // Direction FSM and registered done pulses; masks gate only the pulses.
    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_dir     <= DIR_NONE;
            r_rd_done <= 1'b0;
            r_wr_done <= 1'b0;
        end else begin
            r_dir     <= w_dir_next;
            r_rd_done <= w_rd_evt && !rd_mask_i;
            r_wr_done <= w_wr_evt && !wr_mask_i;
        end
    end

    // Saturating done counters; clear beats a same-cycle increment.
    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else if (cnt_clr_i) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            if (w_rd_evt && (r_rd_cnt != c_cnt_max)) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
            if (w_wr_evt && (r_wr_cnt != c_cnt_max)) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
            end
        end
    end

    // Sticky orphan/conflict flags; clear beats a same-cycle set.
    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_orphan   <= 1'b0;
            r_conflict <= 1'b0;
        end else if (cnt_clr_i) begin
            r_orphan   <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_orphan   <= r_orphan   || w_orphan_evt;
            r_conflict <= r_conflict || w_conflict_evt;
        end
    end

    assign rd_done_o  = r_rd_done;
    assign wr_done_o  = r_wr_done;
    assign dir_o      = r_dir;
    assign rd_cnt_o   = r_rd_cnt;
    assign wr_cnt_o   = r_wr_cnt;
    assign orphan_o   = r_orphan;
    assign conflict_o = r_conflict;

endmodule
`default_nettype wire

// File: rtl/udma_hyper_evt_router.sv
`default_nettype none
// ============================================================================
// Module      : udma_hyper_evt_router
// Description : Steers HyperBus end-of-transfer pulses to per-channel
//               read-done / write-done uDMA events across NB_CH channels.
// Revision    : 1.0 - initial release
// ============================================================================
module udma_hyper_evt_router
    import udma_hyper_evt_router_pkg::*;
#(
    parameter int NB_CH     = 2,
    parameter int CNT_WIDTH = HYPER_EVT_CNT_W
) (
    input  logic                       sys_clk_i,
    input  logic                       rstn_i,
    input  logic [NB_CH-1:0]           rx_evt_i,
    input  logic [NB_CH-1:0]           tx_evt_i,
    input  logic [NB_CH-1:0]           eot_i,
    input  logic [NB_CH-1:0]           cfg_rd_mask_i,
    input  logic [NB_CH-1:0]           cfg_wr_mask_i,
    input  logic [NB_CH-1:0]           cnt_clr_i,
    output logic [NB_CH-1:0]           evt_rd_done_o,
    output logic [NB_CH-1:0]           evt_wr_done_o,
    output logic                       evt_rd_any_o,
    output logic                       evt_wr_any_o,
    output logic [2*NB_CH-1:0]         dir_o,
    output logic [CNT_WIDTH*NB_CH-1:0] rd_cnt_o,
    output logic [CNT_WIDTH*NB_CH-1:0] wr_cnt_o,
    output logic [NB_CH-1:0]           orphan_o,
    output logic [NB_CH-1:0]           conflict_o
);

    // One fully independent channel instance per chip select.
    generate
        for (genvar i = 0; i < NB_CH; i++) begin : g_ch
            hyper_dir_e w_ch_dir;

            udma_hyper_evt_ch #(
                .CNT_WIDTH (CNT_WIDTH)
            ) u_ch (
                .sys_clk_i  (sys_clk_i),
                .rstn_i     (rstn_i),
                .rx_evt_i   (rx_evt_i[i]),
                .tx_evt_i   (tx_evt_i[i]),
                .eot_i      (eot_i[i]),
                .rd_mask_i  (cfg_rd_mask_i[i]),
                .wr_mask_i  (cfg_wr_mask_i[i]),
                .cnt_clr_i  (cnt_clr_i[i]),
                .rd_done_o  (evt_rd_done_o[i]),
                .wr_done_o  (evt_wr_done_o[i]),
                .dir_o      (w_ch_dir),
                .rd_cnt_o   (rd_cnt_o[i*CNT_WIDTH +: CNT_WIDTH]),
                .wr_cnt_o   (wr_cnt_o[i*CNT_WIDTH +: CNT_WIDTH]),
                .orphan_o   (orphan_o[i]),
                .conflict_o (conflict_o[i])
            );

            assign dir_o[2*i +: 2] = w_ch_dir;
        end
    endgenerate

    // Aggregate events are ORs of already-registered pulses, so latency is unchanged.
    assign evt_rd_any_o = |evt_rd_done_o;
    assign evt_wr_any_o = |evt_wr_done_o;

endmodule
`default_nettype wire

// File: tb/tb_udma_hyper_evt_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_udma_hyper_evt_router
// Description : Scoreboard bench for udma_hyper_evt_router: directed scenarios
//               plus randomized traffic against a behavioural channel model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_udma_hyper_evt_router;

    localparam int NB_CH = 2;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic                 clk  = 1'b0;
    logic                 rstn = 1'b0;
    logic [NB_CH-1:0]     rx   = '0;
    logic [NB_CH-1:0]     tx   = '0;
    logic [NB_CH-1:0]     eot  = '0;
    logic [NB_CH-1:0]     rdm  = '0;
    logic [NB_CH-1:0]     wrm  = '0;
    logic [NB_CH-1:0]     clr  = '0;
    logic [NB_CH-1:0]     rd_done, wr_done, orphan, conflict;
    logic                 rd_any, wr_any;
    logic [2*NB_CH-1:0]   dir;
    logic [CW*NB_CH-1:0]  rd_cnt, wr_cnt;

    udma_hyper_evt_router #(
        .NB_CH     (NB_CH),
        .CNT_WIDTH (CW)
    ) dut (
        .sys_clk_i     (clk),
        .rstn_i        (rstn),
        .rx_evt_i      (rx),
        .tx_evt_i      (tx),
        .eot_i         (eot),
        .cfg_rd_mask_i (rdm),
        .cfg_wr_mask_i (wrm),
        .cnt_clr_i     (clr),
        .evt_rd_done_o (rd_done),
        .evt_wr_done_o (wr_done),
        .evt_rd_any_o  (rd_any),
        .evt_wr_any_o  (wr_any),
        .dir_o         (dir),
        .rd_cnt_o      (rd_cnt),
        .wr_cnt_o      (wr_cnt),
        .orphan_o      (orphan),
        .conflict_o    (conflict)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NB_CH-1:0]    rd_done;
        logic [NB_CH-1:0]    wr_done;
        logic                rd_any;
        logic                wr_any;
        logic [2*NB_CH-1:0]  dir;
        logic [CW*NB_CH-1:0] rd_cnt;
        logic [CW*NB_CH-1:0] wr_cnt;
        logic [NB_CH-1:0]    orphan;
        logic [NB_CH-1:0]    conflict;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model state: direction as a name-level code (0 none, 1 read, 2 write).
    int   m_dir   [NB_CH];
    int   m_rdc   [NB_CH];
    int   m_wrc   [NB_CH];
    bit   m_orph  [NB_CH];
    bit   m_conf  [NB_CH];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NB_CH; c++) begin
            m_dir[c]  = 0;
            m_rdc[c]  = 0;
            m_wrc[c]  = 0;
            m_orph[c] = 1'b0;
            m_conf[c] = 1'b0;
        end
    endtask

    // Apply one cycle of stimulus and queue the response expected after the next edge.
    task automatic drive(input logic [NB_CH-1:0] r, input logic [NB_CH-1:0] t,
                         input logic [NB_CH-1:0] e, input logic [NB_CH-1:0] rm,
                         input logic [NB_CH-1:0] wm, input logic [NB_CH-1:0] c);
        exp_t ex;
        @(negedge clk);
        rx = r; tx = t; eot = e; rdm = rm; wrm = wm; clr = c;
        ex.rd_done = '0; ex.wr_done = '0; ex.dir = '0;
        ex.rd_cnt = '0; ex.wr_cnt = '0; ex.orphan = '0; ex.conflict = '0;
        for (int ch = 0; ch < NB_CH; ch++) begin
            if (r[ch] && !t[ch]) m_dir[ch] = 1;
            else if (t[ch] && !r[ch]) m_dir[ch] = 2;
            if (r[ch] && t[ch]) m_conf[ch] = 1'b1;
            if (e[ch]) begin
                if (m_dir[ch] == 1) begin
                    ex.rd_done[ch] = !rm[ch];
                    if (m_rdc[ch] < CMAX) m_rdc[ch]++;
                end else if (m_dir[ch] == 2) begin
                    ex.wr_done[ch] = !wm[ch];
                    if (m_wrc[ch] < CMAX) m_wrc[ch]++;
                end else begin
                    m_orph[ch] = 1'b1;
                end
            end
            if (c[ch]) begin
                m_rdc[ch] = 0; m_wrc[ch] = 0; m_orph[ch] = 1'b0; m_conf[ch] = 1'b0;
            end
            ex.dir[2*ch +: 2]     = 2'(m_dir[ch]);
            ex.rd_cnt[ch*CW +: CW] = CW'(m_rdc[ch]);
            ex.wr_cnt[ch*CW +: CW] = CW'(m_wrc[ch]);
            ex.orphan[ch]          = m_orph[ch];
            ex.conflict[ch]        = m_conf[ch];
        end
        ex.rd_any = |ex.rd_done;
        ex.wr_any = |ex.wr_done;
        sb_q.push_back(ex);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive('0, '0, '0, rdm, wrm, '0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_done"},  64'(rd_done),  64'd0);
        check({tag, "_wr_done"},  64'(wr_done),  64'd0);
        check({tag, "_rd_any"},   64'(rd_any),   64'd0);
        check({tag, "_wr_any"},   64'(wr_any),   64'd0);
        check({tag, "_dir"},      64'(dir),      64'd0);
        check({tag, "_rd_cnt"},   64'(rd_cnt),   64'd0);
        check({tag, "_wr_cnt"},   64'(wr_cnt),   64'd0);
        check({tag, "_orphan"},   64'(orphan),   64'd0);
        check({tag, "_conflict"}, 64'(conflict), 64'd0);
    endtask

    // Monitor: pops one expectation per active clock and compares every output.
    initial begin
        exp_t ex;
        forever begin
            @(posedge clk);
            #1;
            if (rstn && sb_q.size() > 0) begin
                ex = sb_q.pop_front();
                check("rd_done",  64'(rd_done),  64'(ex.rd_done));
                check("wr_done",  64'(wr_done),  64'(ex.wr_done));
                check("rd_any",   64'(rd_any),   64'(ex.rd_any));
                check("wr_any",   64'(wr_any),   64'(ex.wr_any));
                check("dir",      64'(dir),      64'(ex.dir));
                check("rd_cnt",   64'(rd_cnt),   64'(ex.rd_cnt));
                check("wr_cnt",   64'(wr_cnt),   64'(ex.wr_cnt));
                check("orphan",   64'(orphan),   64'(ex.orphan));
                check("conflict", 64'(conflict), 64'(ex.conflict));
            end
        end
    end

    // Stimulus: directed scenarios, random traffic, mid-run reset, more random traffic.
    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rstn = 1'b1;

        // EOT with no known direction is an orphan; clear drops the flag.
        drive('0, '0, 2'b01, '0, '0, '0);
        drive('0, '0, '0, '0, '0, 2'b01);

        // Write direction set by TX, EOT three cycles later.
        drive('0, 2'b01, '0, '0, '0, '0);
        idle(2);
        drive('0, '0, 2'b01, '0, '0, '0);
        idle(1);

        // RX and EOT in the same cycle on channel 1 classify as a read.
        drive(2'b10, '0, 2'b10, '0, '0, '0);
        idle(1);

        // Conflict while reading holds the read direction.
        drive(2'b01, '0, '0, '0, '0, '0);
        drive(2'b01, 2'b01, '0, '0, '0, '0);
        drive('0, '0, 2'b01, '0, '0, '0);

        // Masked reads still count and saturate; back-to-back EOTs.
        for (int k = 0; k < 20; k++) drive('0, '0, 2'b01, 2'b01, '0, '0);
        idle(1);
        drive('0, '0, 2'b11, '0, '0, '0);
        drive('0, 2'b10, 2'b11, '0, '0, 2'b01);

        for (int k = 0; k < 400; k++) begin
            drive(NB_CH'($urandom & $urandom), NB_CH'($urandom & $urandom),
                  NB_CH'($urandom), NB_CH'($urandom), NB_CH'($urandom),
                  NB_CH'($urandom & $urandom & $urandom));
        end

        // Asynchronous reset while an EOT is pending mid-cycle.
        drive(2'b10, '0, '0, '0, '0, '0);
        @(negedge clk);
        eot = 2'b10;
        #2;
        rstn = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        rx = '0; tx = '0; eot = '0; rdm = '0; wrm = '0; clr = '0;
        @(negedge clk);
        rstn = 1'b1;
        drive('0, '0, 2'b10, '0, '0, '0);
        idle(1);

        for (int k = 0; k < 300; k++) begin
            drive(NB_CH'($urandom & $urandom), NB_CH'($urandom & $urandom),
                  NB_CH'($urandom), NB_CH'($urandom), NB_CH'($urandom),
                  NB_CH'($urandom & $urandom & $urandom & $urandom));
        end

        idle(2);
        @(negedge clk);
        check("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
